pipe_stall_ctrl: RTL and testbench

//  Central pipeline sequencer for the RV32I core.
//  - Merges stall requests from ID (load-use), EX (multi-cycle AES/ALU op) and MEM (bus wait) into stall[5:0].
//  - Sequences EX multi-cycle ops with a timeout.
//  - Arbitrates branch redirects from ID and EX, holding a redirect pending while MEM freezes the pipe.
//  - stall[] and the redirect flags drive every pipeline register, including the IF/ID register (bubble when stall[1]&!stall[2]).

---
 rtl/pipe_stall_ctrl_pkg.sv | 29 ++
 rtl/pipe_stall_ctrl_redirect_hold.sv | 69 ++++++
 rtl/pipe_stall_ctrl.sv | 97 +++++++++
 tb/tb_pipe_stall_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pipe_stall_ctrl_pkg : stall vectors, sequencer state and redirect encodings
// Rev 1.0
// ============================================================================
package pipe_stall_ctrl_pkg;

  localparam int              c_addr_w    = 32;
  localparam logic [c_addr_w-1:0] c_zero_word = '0;

  // One bit per pipeline register: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB
  localparam logic [5:0] c_stall_none = 6'b000000;
  localparam logic [5:0] c_stall_id   = 6'b000011;
  localparam logic [5:0] c_stall_ex   = 6'b000111;
  localparam logic [5:0] c_stall_mem  = 6'b001111;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_FAULT   = 2'd2
  } ctrl_state_t;

  typedef enum logic {
    SRC_ID = 1'b0,
    SRC_EX = 1'b1
  } redir_src_t;

endpackage
`default_nettype wire

// File: rtl/pipe_stall_ctrl_redirect_hold.sv
`default_nettype none
// ============================================================================
// pipe_stall_ctrl_redirect_hold : EX-over-ID redirect priority plus one-slot
// pending register that parks a redirect while MEM freezes the pipe.
// Rev 1.0
// ============================================================================
module pipe_stall_ctrl_redirect_hold
  import pipe_stall_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_stall,
  input  logic                id_b_req,
  input  logic [c_addr_w-1:0] id_b_target,
  input  logic                ex_b_req,
  input  logic [c_addr_w-1:0] ex_b_target,
  output logic                id_b_flag,
  output logic                ex_b_flag,
  output logic [c_addr_w-1:0] redirect_pc
);

  logic                r_pend_valid;
  redir_src_t          r_pend_src;
  logic [c_addr_w-1:0] r_pend_target;

  // A parked redirect always beats fresh requests on the release cycle.
  always_comb begin
    id_b_flag   = 1'b0;
    ex_b_flag   = 1'b0;
    redirect_pc = c_zero_word;
    if (!mem_stall) begin
      if (r_pend_valid) begin
        ex_b_flag   = (r_pend_src == SRC_EX);
        id_b_flag   = (r_pend_src == SRC_ID);
        redirect_pc = r_pend_target;
      end else if (ex_b_req) begin
        ex_b_flag   = 1'b1;
        redirect_pc = ex_b_target;
      end else if (id_b_req) begin
        id_b_flag   = 1'b1;
        redirect_pc = id_b_target;
      end
    end
  end

  // EX redirects belong to an older instruction, so they may replace a parked
  // one; an ID redirect only fills an empty slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_valid  <= 1'b0;
      r_pend_src    <= SRC_ID;
      r_pend_target <= c_zero_word;
    end else if (mem_stall) begin
      if (ex_b_req) begin
        r_pend_valid  <= 1'b1;
        r_pend_src    <= SRC_EX;
        r_pend_target <= ex_b_target;
      end else if (id_b_req && !r_pend_valid) begin
        r_pend_valid  <= 1'b1;
        r_pend_src    <= SRC_ID;
        r_pend_target <= id_b_target;
      end
    end else begin
      r_pend_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_stall_ctrl : RV32I pipeline sequencer - stall merge, multi-cycle EX
// timeout FSM, redirect arbitration and stall-cycle performance counter.
// Rev 1.0
// ============================================================================
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                ex_mc_start,
  input  logic                ex_mc_done,
  input  logic                stallreq_mem,
  input  logic                id_b_req,
  input  logic [c_addr_w-1:0] id_b_target,
  input  logic                ex_b_req,
  input  logic [c_addr_w-1:0] ex_b_target,
  output logic [5:0]          stall,
  output logic                id_b_flag,
  output logic                ex_b_flag,
  output logic [c_addr_w-1:0] redirect_pc,
  output logic                mc_fault,
  output logic [CNT_W-1:0]    stall_cycles
);

  localparam int              c_mc_w    = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [c_mc_w-1:0] c_mc_last = c_mc_w'(MC_TIMEOUT - 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_state_nxt;
  logic [c_mc_w-1:0] r_mc_cnt;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic              w_mc_expire;

  // Cycles frozen by a MEM stall do not count against the timeout.
  assign w_mc_expire = (r_mc_cnt == c_mc_last) && !ex_mc_done && !stallreq_mem;

  always_comb begin
    w_state_nxt = r_state;
    stall       = c_stall_none;
    case (r_state)
      ST_RUN:     if (ex_mc_start) w_state_nxt = ST_MC_WAIT;
      ST_MC_WAIT: begin
        if (ex_mc_done)       w_state_nxt = ST_RUN;
        else if (w_mc_expire) w_state_nxt = ST_FAULT;
      end
      ST_FAULT:   w_state_nxt = ST_FAULT;
      default:    w_state_nxt = ST_RUN;
    endcase

    if (r_state == ST_FAULT)                        stall = c_stall_ex;
    else if (stallreq_mem)                          stall = c_stall_mem;
    else if (r_state == ST_MC_WAIT && !ex_mc_done)  stall = c_stall_ex;
    else if (stallreq_id)                           stall = c_stall_id;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_RUN;
      r_mc_cnt       <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_RUN) begin
        r_mc_cnt <= '0;
      end else if (r_state == ST_MC_WAIT && !stallreq_mem) begin
        r_mc_cnt <= r_mc_cnt + 1'b1;
      end
      if (stall[0] && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign mc_fault     = (r_state == ST_FAULT);
  assign stall_cycles = r_stall_cycles;

  pipe_stall_ctrl_redirect_hold u_redirect_hold (
    .clk         (clk),
    .rst         (rst),
    .mem_stall   (stallreq_mem),
    .id_b_req    (id_b_req),
    .id_b_target (id_b_target),
    .ex_b_req    (ex_b_req),
    .ex_b_target (ex_b_target),
    .id_b_flag   (id_b_flag),
    .ex_b_flag   (ex_b_flag),
    .redirect_pc (redirect_pc)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_stall_ctrl : directed self-checking bench (MC_TIMEOUT=8, CNT_W=4)
// Rev 1.0
// ============================================================================
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        ex_mc_start = 1'b0;
  logic        ex_mc_done = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic        id_b_req = 1'b0;
  logic [31:0] id_b_target = 32'h0;
  logic        ex_b_req = 1'b0;
  logic [31:0] ex_b_target = 32'h0;
  logic [5:0]  stall;
  logic        id_b_flag;
  logic        ex_b_flag;
  logic [31:0] redirect_pc;
  logic        mc_fault;
  logic [3:0]  stall_cycles;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MC_TIMEOUT(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_done   (ex_mc_done),
    .stallreq_mem (stallreq_mem),
    .id_b_req     (id_b_req),
    .id_b_target  (id_b_target),
    .ex_b_req     (ex_b_req),
    .ex_b_target  (ex_b_target),
    .stall        (stall),
    .id_b_flag    (id_b_flag),
    .ex_b_flag    (ex_b_flag),
    .redirect_pc  (redirect_pc),
    .mc_fault     (mc_fault),
    .stall_cycles (stall_cycles)
  );

  // Drive one cycle of inputs at the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic sid, input logic start, input logic done, input logic mem,
                       input logic idr, input logic [31:0] idt, input logic exr, input logic [31:0] ext);
    @(negedge clk);
    stallreq_id = sid; ex_mc_start = start; ex_mc_done = done; stallreq_mem = mem;
    id_b_req = idr; id_b_target = idt; ex_b_req = exr; ex_b_target = ext;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    stallreq_id = 0; ex_mc_start = 0; ex_mc_done = 0; stallreq_mem = 0;
    id_b_req = 0; id_b_target = 0; ex_b_req = 0; ex_b_target = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    idle();
    checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL reset_stall got=%b exp=000000", stall); end
    checks++; if (id_b_flag !== 1'b0) begin failures++; $display("FAIL reset_id_flag got=%b exp=0", id_b_flag); end
    checks++; if (ex_b_flag !== 1'b0) begin failures++; $display("FAIL reset_ex_flag got=%b exp=0", ex_b_flag); end
    checks++; if (mc_fault !== 1'b0) begin failures++; $display("FAIL reset_mc_fault got=%b exp=0", mc_fault); end
    checks++; if (stall_cycles !== 4'd0) begin failures++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    checks++; if (stall !== 6'b000011) begin failures++; $display("FAIL load_use_stall got=%b exp=000011", stall); end
    idle();
    checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL load_use_release got=%b exp=000000", stall); end
    checks++; if (stall_cycles !== 4'd1) begin failures++; $display("FAIL load_use_count got=%0d exp=1", stall_cycles); end
  endtask

  task automatic test_mc_seq();
    drive(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL mc_start_stall got=%b exp=000000", stall); end
    for (int i = 1; i <= 5; i++) begin
      idle();
      checks++; if (stall !== 6'b000111) begin failures++; $display("FAIL mc_wait_stall cyc=%0d got=%b exp=000111", i, stall); end
    end
    drive(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL mc_done_stall got=%b exp=000000", stall); end
    idle();
    checks++; if (stall !== 6'b000000) begin failures++; $display("FAIL mc_back_to_run got=%b exp=000000", stall); end
    checks++; if (stall_cycles !== 4'd6) begin failures++; $display("FAIL mc_count got=%0d exp=6", stall_cycles); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 9; i++) drive(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    drive(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    checks++; if (stall_cycles !== 4'd15) begin failures++; $display("FAIL sat_reach got=%0d exp=15", stall_cycles); end
    for (int i = 0; i < 2; i++) drive(1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
    idle();
    checks++; if (stall_cycles !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", stall_cycles); end
  endtask

  task automatic test_fault();
    do_reset();
    drive(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      idle();
      checks++; if (stall !== 6'b000111 || mc_fault !== 1'b0) begin failures++; $display("FAIL fault_wait cyc=%0d got stall=%b fault=%b exp stall=000111 fault=0", i, stall, mc_fault); end
    end
    idle();
    checks++; if (mc_fault !== 1'b1) begin failures++; $display("FAIL fault_set got=%b exp=1", mc_fault); end
    checks++; if (stall !== 6'b000111) begin failures++; $display("FAIL fault_stall got=%b exp=000111", stall); end
    drive(0, 0, 1, 0, 0, 32'h0, 0, 32'h0);
    checks++; if (stall !== 6'b000111 || mc_fault !== 1'b1) begin failures++; $display("FAIL fault_sticky got stall=%b fault=%b exp stall=000111 fault=1", stall, mc_fault); end
    do_reset();
    idle();
    checks++; if (mc_fault !== 1'b0 || stall !== 6'b000000) begin failures++; $display("FAIL fault_reset got stall=%b fault=%b exp stall=000000 fault=0", stall, mc_fault); end
  endtask

  task automatic test_mc_freeze();
    do_reset();
    drive(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) idle();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
      checks++; if (stall !== 6'b001111) begin failures++; $display("FAIL freeze_mem_stall cyc=%0d got=%b exp=001111", i, stall); end
    end
    for (int i = 0; i < 5; i++) idle();
    checks++; if (mc_fault !== 1'b0) begin failures++; $display("FAIL freeze_not_yet got=%b exp=0", mc_fault); end
    idle();
    checks++; if (mc_fault !== 1'b1) begin failures++; $display("FAIL freeze_fault got=%b exp=1", mc_fault); end
  endtask

  task automatic test_mem_redirect();
    do_reset();
    drive(0, 0, 0, 1, 0, 32'h0, 1, 32'h100);
    checks++; if (ex_b_flag !== 1'b0 || id_b_flag !== 1'b0) begin failures++; $display("FAIL memredir_c0 got ex=%b id=%b exp 0 0", ex_b_flag, id_b_flag); end
    for (int i = 1; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 32'h0, 0, 32'h0);
      checks++; if (ex_b_flag !== 1'b0 || id_b_flag !== 1'b0) begin failures++; $display("FAIL memredir_c%0d got ex=%b id=%b exp 0 0", i, ex_b_flag, id_b_flag); end
    end
    idle();
    checks++; if (ex_b_flag !== 1'b1 || id_b_flag !== 1'b0 || redirect_pc !== 32'h100) begin failures++; $display("FAIL memredir_issue got ex=%b id=%b pc=%h exp ex=1 id=0 pc=00000100", ex_b_flag, id_b_flag, redirect_pc); end
    idle();
    checks++; if (ex_b_flag !== 1'b0 || id_b_flag !== 1'b0) begin failures++; $display("FAIL memredir_pulse got ex=%b id=%b exp 0 0", ex_b_flag, id_b_flag); end
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 0, 0, 1, 32'h40, 1, 32'h80);
    checks++; if (ex_b_flag !== 1'b1 || id_b_flag !== 1'b0 || redirect_pc !== 32'h80) begin failures++; $display("FAIL simul_priority got ex=%b id=%b pc=%h exp ex=1 id=0 pc=00000080", ex_b_flag, id_b_flag, redirect_pc); end
    idle();
    checks++; if (ex_b_flag !== 1'b0 || id_b_flag !== 1'b0) begin failures++; $display("FAIL simul_dropped got ex=%b id=%b exp 0 0", ex_b_flag, id_b_flag); end
    drive(1, 0, 0, 0, 1, 32'h10, 0, 32'h0);
    checks++; if (id_b_flag !== 1'b1 || redirect_pc !== 32'h10 || stall !== 6'b000011) begin failures++; $display("FAIL redir_during_stall got id=%b pc=%h stall=%b exp id=1 pc=00000010 stall=000011", id_b_flag, redirect_pc, stall); end
  endtask

  task automatic test_pending_overwrite();
    drive(0, 0, 0, 1, 1, 32'h40, 0, 32'h0);
    drive(0, 0, 0, 1, 0, 32'h0, 1, 32'h80);
    drive(0, 0, 0, 1, 1, 32'h44, 0, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h200, 0, 32'h0);
    checks++; if (ex_b_flag !== 1'b1 || id_b_flag !== 1'b0 || redirect_pc !== 32'h80) begin failures++; $display("FAIL pend_overwrite got ex=%b id=%b pc=%h exp ex=1 id=0 pc=00000080", ex_b_flag, id_b_flag, redirect_pc); end
    idle();
    checks++; if (ex_b_flag !== 1'b0 || id_b_flag !== 1'b0) begin failures++; $display("FAIL pend_fresh_ignored got ex=%b id=%b exp 0 0", ex_b_flag, id_b_flag); end
    drive(0, 0, 0, 1, 1, 32'h40, 0, 32'h0);
    idle();
    checks++; if (id_b_flag !== 1'b1 || ex_b_flag !== 1'b0 || redirect_pc !== 32'h40) begin failures++; $display("FAIL pend_id_issue got id=%b ex=%b pc=%h exp id=1 ex=0 pc=00000040", id_b_flag, ex_b_flag, redirect_pc); end
  endtask

  task automatic test_reset_clears();
    drive(0, 0, 0, 1, 0, 32'h0, 1, 32'h300);
    do_reset();
    idle();
    checks++; if (ex_b_flag !== 1'b0 || id_b_flag !== 1'b0) begin failures++; $display("FAIL rst_pending got ex=%b id=%b exp 0 0", ex_b_flag, id_b_flag); end
    drive(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    idle();
    idle();
    do_reset();
    idle();
    checks++; if (stall !== 6'b000000 || stall_cycles !== 4'd0) begin failures++; $display("FAIL rst_mc_wait got stall=%b cnt=%0d exp stall=000000 cnt=0", stall, stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mc_seq();
    test_saturation();
    test_fault();
    test_mc_freeze();
    test_mem_redirect();
    test_back_to_back();
    test_pending_overwrite();
    test_reset_clears();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
